// File: rtl/dm_port_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : dm_port_arbiter
// Purpose : Shares the data-memory port between the CPU MEM stage (pass-through)
//           and a word-burst DMA requester (whole bursts, CPU stalled meanwhile).
// Option  : DM_ARB_RR_EN -> after each burst the CPU wins one contended access;
//           undefined     -> fixed CPU priority.
// Rev     : 1.0  initial release
// =============================================================================
module dm_port_arbiter #(
   parameter int MAX_LEN_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [31:0]          cpu_addr,
   input  logic [31:0]          cpu_wdata,
   input  logic [2:0]           cpu_width,
   input  logic                 cpu_sign,
   output logic [31:0]          cpu_rdata,
   output logic                 cpu_stall,
   input  logic                 dma_req,
   input  logic                 dma_we,
   input  logic [31:0]          dma_addr,
   input  logic [MAX_LEN_W-1:0] dma_len,
   input  logic [31:0]          dma_wdata,
   output logic                 dma_gnt,
   output logic                 dma_ack,
   output logic [31:0]          dma_rdata,
   output logic                 dma_done,
   output logic [31:0]          dm_addr,
   output logic [31:0]          dm_wdata,
   output logic                 dm_we,
   output logic [2:0]           dm_width,
   output logic                 dm_sign,
   input  logic [31:0]          dm_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [MAX_LEN_W:0] c_last_word = (MAX_LEN_W+1)'(1);
   localparam logic [MAX_LEN_W:0] c_full_len  = (MAX_LEN_W+1)'(1) << MAX_LEN_W;

   state_t               state;
   state_t               state_nxt;
   logic [31:0]          base;
   logic [MAX_LEN_W:0]   cnt;
   logic [MAX_LEN_W-1:0] idx;
   logic                 dir;
   logic                 eligible;
   logic                 grant;
   logic [MAX_LEN_W:0]   len_words;

`ifdef DM_ARB_RR_EN
   logic cpu_turn;

   assign eligible = !cpu_req || !cpu_turn;

   // A CPU access served in DONE consumes the turn it would otherwise be owed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cpu_turn <= 1'b0;
      end else if (state != BURST && cpu_req && !cpu_stall) begin
         cpu_turn <= 1'b0;
      end else if (state == DONE) begin
         cpu_turn <= 1'b1;
      end
   end
`else
   assign eligible = !cpu_req;
`endif

   // Gated by reset so no grant can leak out while the FSM is held.
   assign grant     = reset && (state == IDLE) && dma_req && eligible;
   assign len_words = (dma_len == '0) ? c_full_len : {1'b0, dma_len};

   assign dma_gnt   = grant;
   assign cpu_stall = cpu_req && ((state == BURST) || grant);
   assign cpu_rdata = dm_rdata;
   assign dma_rdata = dm_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         base  <= '0;
         cnt   <= '0;
         idx   <= '0;
         dir   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            base <= {dma_addr[31:2], 2'b00};
            cnt  <= len_words;
            idx  <= '0;
            dir  <= dma_we;
         end else if (state == BURST) begin
            cnt <= cnt - c_last_word;
            idx <= idx + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      dm_addr   = cpu_addr;
      dm_wdata  = cpu_wdata;
      dm_we     = reset && cpu_req && cpu_we && !grant;
      dm_width  = cpu_width;
      dm_sign   = cpu_sign;
      dma_ack   = 1'b0;
      dma_done  = 1'b0;
      case (state)
         IDLE: begin
            if (grant) begin
               state_nxt = BURST;
            end
         end
         BURST: begin
            dm_addr  = base + {{(30-MAX_LEN_W){1'b0}}, idx, 2'b00};
            dm_wdata = dma_wdata;
            dm_we    = dir;
            dm_width = 3'd4;
            dm_sign  = 1'b0;
            dma_ack  = 1'b1;
            if (cnt == c_last_word) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            dma_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// tb_dm_port_arbiter: directed and randomized checks of dm_port_arbiter against
// a cycle-timeline reference model and a byte-addressed data-memory model.
module tb_dm_port_arbiter;
   localparam int MAX_LEN_W = 8;
`ifdef DM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, cpu_sign, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic [2:0]  cpu_width;
   logic        dma_req, dma_we, dma_gnt, dma_ack, dma_done;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic [MAX_LEN_W-1:0] dma_len;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        dm_we, dm_sign;
   logic [2:0]  dm_width;
   logic [4:0]  ctl;

   int vectors;
   int miscompares;

   logic [7:0] mem [0:4095];
   int         mem_gen = 0;

   dm_port_arbiter #(.MAX_LEN_W(MAX_LEN_W)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_width(cpu_width), .cpu_sign(cpu_sign), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
      .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .dma_done(dma_done), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
      .dm_width(dm_width), .dm_sign(dm_sign), .dm_rdata(dm_rdata)
   );

   always #5 clk = ~clk;

   assign ctl = {dma_gnt, dma_ack, dma_done, cpu_stall, dm_we};

   // Little-endian byte memory, aliased on the low 12 address bits.
   function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] w,
                                            input logic s);
      logic [31:0] v;
      logic [31:0] ai;
      v = '0;
      for (int i = 0; i < 4; i++) begin
         ai = a + 32'(i);
         if (i < int'(w)) v[8*i +: 8] = mem[ai[11:0]];
      end
      if (s && w == 3'd1) v = {{24{v[7]}}, v[7:0]};
      else if (s && w == 3'd2) v = {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   always @(dm_addr or dm_width or dm_sign or mem_gen)
      dm_rdata = mem_read(dm_addr, dm_width, dm_sign);

   always @(posedge clk) begin
      if (dm_we) begin
         for (int i = 0; i < 4; i++)
            if (i < int'(dm_width)) mem[12'(dm_addr + 32'(i))] <= dm_wdata[8*i +: 8];
         mem_gen <= mem_gen + 1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      cpu_width = 3'd4; cpu_sign = 1'b0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = 8'd1; dma_wdata = '0;
   endtask

   task automatic do_reset;
      set_idle;
      reset = 1'b0;
      tick;
      tick;
      reset = 1'b1;
      tick;
   endtask

   task automatic test_reset;
      cpu_req = 1'b1; cpu_we = 1'b1; dma_req = 1'b1; dma_len = 8'd2;
      reset = 1'b0;
      #1;
      vectors++;
      if (ctl !== 5'b0) begin
         miscompares++; $display("FAIL reset_async: ctl got %b want 00000", ctl);
      end
      tick;
      vectors++;
      if (ctl !== 5'b0) begin
         miscompares++; $display("FAIL reset_hold: ctl got %b want 00000", ctl);
      end
      @(negedge clk);
      reset = 1'b1;
      dma_req = 1'b0;
      tick;
      @(negedge clk);
      vectors++;
      if (ctl !== 5'b00001) begin
         miscompares++; $display("FAIL reset_release: ctl got %b want 00001", ctl);
      end
      tick;
      set_idle;
   endtask

   task automatic test_cpu_access;
      set_idle;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h12345678;
      @(negedge clk);
      vectors++;
      if ({cpu_stall, dm_we, dm_addr, dm_wdata} !== {1'b0, 1'b1, 32'h10, 32'h12345678}) begin
         miscompares++;
         $display("FAIL cpu_sw: stall=%b we=%b addr=%h wdata=%h want 0 1 00000010 12345678",
                  cpu_stall, dm_we, dm_addr, dm_wdata);
      end
      tick;
      cpu_we = 1'b0; cpu_addr = 32'h13; cpu_width = 3'd1; cpu_sign = 1'b1;
      @(negedge clk);
      vectors++;
      if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h00000012) begin
         miscompares++; $display("FAIL cpu_lb_pos: stall=%b rdata=%h want 0 00000012", cpu_stall, cpu_rdata);
      end
      tick;
      cpu_we = 1'b1; cpu_addr = 32'h11; cpu_wdata = 32'h80; cpu_sign = 1'b0;
      tick;
      cpu_we = 1'b0; cpu_sign = 1'b1;
      @(negedge clk);
      vectors++;
      if (cpu_rdata !== 32'hFFFFFF80) begin
         miscompares++; $display("FAIL cpu_lb_neg: rdata=%h want ffffff80", cpu_rdata);
      end
      tick;
      cpu_sign = 1'b0;
      @(negedge clk);
      vectors++;
      if (cpu_rdata !== 32'h00000080) begin
         miscompares++; $display("FAIL cpu_lbu: rdata=%h want 00000080", cpu_rdata);
      end
      tick;
      cpu_addr = 32'h10; cpu_width = 3'd2; cpu_sign = 1'b1;
      @(negedge clk);
      vectors++;
      if (cpu_rdata !== 32'hFFFF8078) begin
         miscompares++; $display("FAIL cpu_lh: rdata=%h want ffff8078", cpu_rdata);
      end
      tick;
      set_idle;
   endtask

   task automatic test_dma_write;
      set_idle;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h103; dma_len = 8'd3;
      @(negedge clk);
      vectors++;
      if (ctl !== 5'b10000) begin
         miscompares++; $display("FAIL dma_wr_gnt: ctl got %b want 10000", ctl);
      end
      tick;
      dma_req = 1'b0; dma_addr = 32'hDEAD0000; dma_len = 8'd9;
      for (int k = 0; k < 3; k++) begin
         dma_wdata = 32'hA + 32'(k);
         @(negedge clk);
         vectors++;
         if ({dma_ack, dm_we, dm_width, dm_addr, dm_wdata} !==
             {1'b1, 1'b1, 3'd4, 32'h100 + 32'(4*k), 32'hA + 32'(k)}) begin
            miscompares++;
            $display("FAIL dma_wr_word%0d: ack=%b we=%b width=%0d addr=%h wdata=%h want 1 1 4 %h %h",
                     k, dma_ack, dm_we, dm_width, dm_addr, dm_wdata, 32'h100 + 32'(4*k), 32'hA + 32'(k));
         end
         tick;
      end
      @(negedge clk);
      vectors++;
      if (ctl !== 5'b00100) begin
         miscompares++; $display("FAIL dma_wr_done: ctl got %b want 00100", ctl);
      end
      tick;
      @(negedge clk);
      vectors++;
      if (dma_done !== 1'b0) begin
         miscompares++; $display("FAIL dma_wr_done_pulse: done got %b want 0", dma_done);
      end
      for (int k = 0; k < 3; k++) begin
         tick;
         cpu_req = 1'b1; cpu_addr = 32'h100 + 32'(4*k);
         @(negedge clk);
         vectors++;
         if (cpu_stall !== 1'b0 || cpu_rdata !== 32'hA + 32'(k)) begin
            miscompares++;
            $display("FAIL dma_wr_readback%0d: stall=%b rdata=%h want 0 %h", k, cpu_stall, cpu_rdata, 32'hA + 32'(k));
         end
      end
      tick;
      set_idle;
   endtask

   task automatic test_dma_wrap;
      logic [31:0] exp_a;
      int          acks;
      bit          seen_done;
      set_idle;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFFFFFC; cpu_wdata = 32'hCAFEF00D;
      tick;
      cpu_addr = 32'h0; cpu_wdata = 32'h600DBEEF;
      tick;
      set_idle;
      dma_req = 1'b1; dma_addr = 32'hFFFFFE02; dma_len = 8'd0;
      @(negedge clk);
      vectors++;
      if (dma_gnt !== 1'b1) begin
         miscompares++; $display("FAIL dma_wrap_gnt: gnt got %b want 1", dma_gnt);
      end
      tick;
      dma_req = 1'b0;
      acks = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 300 && !seen_done; c++) begin
         @(negedge clk);
         if (dma_done) begin
            seen_done = 1'b1;
         end else if (dma_ack) begin
            exp_a = 32'hFFFFFE00 + 32'(4*acks);
            vectors++;
            if (dm_addr !== exp_a || dm_we !== 1'b0 || dma_rdata !== mem_read(exp_a, 3'd4, 1'b0)) begin
               miscompares++;
               $display("FAIL dma_wrap_word%0d: addr=%h we=%b rdata=%h want %h 0 %h",
                        acks, dm_addr, dm_we, dma_rdata, exp_a, mem_read(exp_a, 3'd4, 1'b0));
            end
            acks++;
         end
         tick;
      end
      vectors++;
      if (!seen_done || acks != 256) begin
         miscompares++; $display("FAIL dma_wrap_len: acks=%0d done_seen=%b want 256 1", acks, seen_done);
      end
      set_idle;
   endtask

   task automatic test_stall;
      set_idle;
      dma_req = 1'b1; dma_addr = 32'h400; dma_len = 8'd4;
      @(negedge clk);
      vectors++;
      if (dma_gnt !== 1'b1 || cpu_stall !== 1'b0) begin
         miscompares++; $display("FAIL stall_gnt: gnt=%b stall=%b want 1 0", dma_gnt, cpu_stall);
      end
      tick;
      dma_req = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'h55AA55AA;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         vectors++;
         if ({cpu_stall, dm_we, dma_ack} !== 3'b101 || dm_addr !== 32'h400 + 32'(4*k)) begin
            miscompares++;
            $display("FAIL stall_burst%0d: stall=%b we=%b ack=%b addr=%h want 1 0 1 %h",
                     k, cpu_stall, dm_we, dma_ack, dm_addr, 32'h400 + 32'(4*k));
         end
         tick;
      end
      @(negedge clk);
      vectors++;
      if ({dma_done, cpu_stall, dm_we} !== 3'b101 || dm_addr !== 32'h200) begin
         miscompares++;
         $display("FAIL stall_done_served: done=%b stall=%b we=%b addr=%h want 1 0 1 00000200",
                  dma_done, cpu_stall, dm_we, dm_addr);
      end
      tick;
      cpu_we = 1'b0;
      @(negedge clk);
      vectors++;
      if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h55AA55AA) begin
         miscompares++; $display("FAIL stall_readback: stall=%b rdata=%h want 0 55aa55aa", cpu_stall, cpu_rdata);
      end
      tick;
      set_idle;
   endtask

   task automatic test_contention;
      bit exp_g, exp_s;
      do_reset;
      cpu_req = 1'b1; cpu_addr = 32'h10;
      dma_req = 1'b1; dma_addr = 32'h800; dma_len = 8'd2;
      // Period of 4 under round-robin: grant, two words, DONE (CPU served).
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         exp_g = RR && (c % 4 == 0);
         exp_s = RR && (c % 4 != 3);
         vectors++;
         if ({dma_gnt, cpu_stall} !== {exp_g, exp_s}) begin
            miscompares++;
            $display("FAIL contention_c%0d: gnt=%b stall=%b want %b %b", c, dma_gnt, cpu_stall, exp_g, exp_s);
         end
         tick;
      end
      set_idle;
      tick;
   endtask

   task automatic test_reset_mid_burst;
      set_idle;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h300; dma_len = 8'd4; dma_wdata = 32'h11;
      @(negedge clk);
      vectors++;
      if (dma_gnt !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_gnt: gnt got %b want 1", dma_gnt);
      end
      tick;
      dma_req = 1'b0;
      tick;
      vectors++;
      if (dma_ack !== 1'b1 || dm_addr !== 32'h304) begin
         miscompares++; $display("FAIL rstmid_pre: ack=%b addr=%h want 1 00000304", dma_ack, dm_addr);
      end
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h500;
      reset = 1'b0;
      #1;
      vectors++;
      if (ctl !== 5'b0) begin
         miscompares++; $display("FAIL rstmid_async: ctl got %b want 00000", ctl);
      end
      for (int c = 0; c < 2; c++) begin
         tick;
         @(negedge clk);
         vectors++;
         if (ctl !== 5'b0) begin
            miscompares++; $display("FAIL rstmid_hold%0d: ctl got %b want 00000", c, ctl);
         end
      end
      reset = 1'b1;
      set_idle;
      for (int c = 0; c < 3; c++) begin
         tick;
         @(negedge clk);
         vectors++;
         if ({dma_ack, dma_done} !== 2'b00) begin
            miscompares++; $display("FAIL rstmid_nodone%0d: ack=%b done=%b want 0 0", c, dma_ack, dma_done);
         end
      end
      tick;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h600; dma_len = 8'd1; dma_wdata = 32'h77;
      @(negedge clk);
      vectors++;
      if (dma_gnt !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_regnt: gnt got %b want 1", dma_gnt);
      end
      tick;
      dma_req = 1'b0;
      @(negedge clk);
      vectors++;
      if (dma_ack !== 1'b1 || dm_addr !== 32'h600 || dm_we !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_reword: ack=%b addr=%h we=%b want 1 00000600 1", dma_ack, dm_addr, dm_we);
      end
      tick;
      @(negedge clk);
      vectors++;
      if (dma_done !== 1'b1) begin
         miscompares++; $display("FAIL rstmid_redone: done got %b want 1", dma_done);
      end
      tick;
      set_idle;
   endtask

   task automatic test_random;
      int          g_at, g_len, k;
      bit          g_dir, cpu_pri, in_burst, in_done, exp_g, exp_s, exp_we;
      logic [31:0] g_base, exp_a, exp_wd, exp_rd;
      logic [2:0]  exp_w;
      logic        exp_sg;
      do_reset;
      g_at = -1000; g_len = 0; g_dir = 1'b0; g_base = '0; cpu_pri = 1'b0;
      for (int c = 0; c < 2500; c++) begin
         cpu_req   = ($urandom_range(0, 9) < 6);
         cpu_we    = 1'($urandom_range(0, 1));
         cpu_addr  = $urandom;
         cpu_wdata = $urandom;
         case ($urandom_range(0, 2))
            0:       cpu_width = 3'd1;
            1:       cpu_width = 3'd2;
            default: cpu_width = 3'd4;
         endcase
         cpu_sign  = 1'($urandom_range(0, 1));
         dma_wdata = $urandom;
         if (!dma_req && $urandom_range(0, 4) == 0) begin
            dma_req  = 1'b1;
            dma_we   = 1'($urandom_range(0, 1));
            dma_addr = $urandom;
            dma_len  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
         end
         @(negedge clk);
         // Timeline of the last grant: words at +1..+len, done at +len+1.
         k        = c - g_at;
         in_burst = (k >= 1) && (k <= g_len);
         in_done  = (k == g_len + 1);
         exp_g    = !in_burst && !in_done && dma_req && (!cpu_req || (RR && !cpu_pri));
         exp_s    = cpu_req && (in_burst || exp_g);
         exp_we   = in_burst ? g_dir : (cpu_req && cpu_we && !exp_g);
         exp_a    = in_burst ? g_base + 32'(4*(k-1)) : cpu_addr;
         exp_wd   = in_burst ? dma_wdata : cpu_wdata;
         exp_w    = in_burst ? 3'd4 : cpu_width;
         exp_sg   = in_burst ? 1'b0 : cpu_sign;
         vectors++;
         if (ctl !== {exp_g, in_burst, in_done, exp_s, exp_we}) begin
            miscompares++;
            $display("FAIL rand_ctl c=%0d: gnt/ack/done/stall/we got %b want %b",
                     c, ctl, {exp_g, in_burst, in_done, exp_s, exp_we});
         end
         vectors++;
         if (dm_addr !== exp_a || dm_wdata !== exp_wd || dm_width !== exp_w || dm_sign !== exp_sg) begin
            miscompares++;
            $display("FAIL rand_port c=%0d: addr=%h wdata=%h width=%0d sign=%b want %h %h %0d %b",
                     c, dm_addr, dm_wdata, dm_width, dm_sign, exp_a, exp_wd, exp_w, exp_sg);
         end
         if (in_burst && !g_dir) begin
            exp_rd = mem_read(exp_a, 3'd4, 1'b0);
            vectors++;
            if (dma_rdata !== exp_rd) begin
               miscompares++; $display("FAIL rand_dma_rdata c=%0d: got %h want %h", c, dma_rdata, exp_rd);
            end
         end
         if (cpu_req && !exp_s && !cpu_we) begin
            exp_rd = mem_read(cpu_addr, cpu_width, cpu_sign);
            vectors++;
            if (cpu_rdata !== exp_rd) begin
               miscompares++; $display("FAIL rand_cpu_rdata c=%0d: got %h want %h", c, cpu_rdata, exp_rd);
            end
         end
         if (exp_g) begin
            g_at   = c;
            g_len  = (dma_len == 8'd0) ? 256 : int'(dma_len);
            g_base = {dma_addr[31:2], 2'b00};
            g_dir  = dma_we;
         end
         if (in_done) cpu_pri = 1'b1;
         if (!in_burst && cpu_req && !exp_s) cpu_pri = 1'b0;
         tick;
         if (exp_g) dma_req = 1'b0;
      end
      set_idle;
      tick;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      reset = 1'b1;
      set_idle;
      #3;
      test_reset;
      test_cpu_access;
      test_dma_write;
      test_dma_wrap;
      test_stall;
      test_contention;
      test_reset_mid_burst;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running at time limit, want completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
